// File: rtl/divider_pkg.sv
// Shared constants for the sequential restoring divider: state encoding,
// default operand width and iteration counter sizing.
package divider_pkg;

    localparam int unsigned DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold 0..w-1; keep at least one bit for w == 1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/ripple_subtractor.sv
// Ripple-borrow subtractor: diff = a - b, borrow_o set when a < b.
// Each bit is a full-subtractor cell, the dual of the ripple-carry adder's full-adder.
module ripple_subtractor #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] bw;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_cell
        assign diff_o[i] = a_i[i] ^ b_i[i] ^ bw[i];
        assign bw[i+1]   = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bw[i]);
    end

    assign borrow_o = bw[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// start/busy/done handshake and a sticky divide-by-zero flag held with the result.
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam int unsigned   SW       = WIDTH + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [SW-1:0]    r_shift;
    logic [SW-1:0]    trial;
    logic             borrow;
    logic [WIDTH-1:0] r_iter;
    logic [WIDTH-1:0] q_iter;
    logic             last_iter;

    // One restoring step: shift {R,Q} left, try R' - D, keep or restore.
    assign r_shift = {r_q, q_q[WIDTH-1]};

    ripple_subtractor #(
        .W(SW)
    ) u_sub (
        .a_i      (r_shift),
        .b_i      ({1'b0, d_q}),
        .diff_o   (trial),
        .borrow_o (borrow)
    );

    assign r_iter    = borrow ? WIDTH'(r_shift) : WIDTH'(trial);
    assign q_iter    = WIDTH'({q_q, ~borrow});
    assign last_iter = (cnt_q == LAST_CNT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d = '1;
                        rem_d  = dividend;
                        dbz_d  = 1'b1;
                    end else begin
                        r_d   = '0;
                        q_d   = dividend;
                        d_d   = divisor;
                        cnt_d = '0;
                        dbz_d = 1'b0;
                    end
                end
            end
            CALC: begin
                r_d   = r_iter;
                q_d   = q_iter;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    quot_d = q_iter;
                    rem_d  = r_iter;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed vectors, handshake
// corner cases, exhaustive back-to-back sweep and random ops against a plain arithmetic model.
module tb_seq_restoring_divider;

    localparam int W       = 4;
    localparam int ALL_ONE = (1 << W) - 1;
    localparam int BOUND   = 20;

    logic         clock;
    logic         resetn;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = ALL_ONE;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endtask

    // Pulse start from IDLE; lat = edges after the start edge until done is seen.
    task automatic do_op(input int a, input int b, output int lat, output int busy_cycles);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start       = 1'b0;
        lat         = 0;
        busy_cycles = 0;
        while (!done && lat < BOUND) begin
            if (busy) busy_cycles++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, q, r, z, ndone;
        bit seen;

        vecs[0] = '{a: 13, b: 4, q: 3,       r: 1, z: 0};
        vecs[1] = '{a: 15, b: 1, q: 15,      r: 0, z: 0};
        vecs[2] = '{a: 7,  b: 9, q: 0,       r: 7, z: 0};
        vecs[3] = '{a: 9,  b: 0, q: ALL_ONE, r: 9, z: 1};
        vecs[4] = '{a: 6,  b: 3, q: 2,       r: 0, z: 0};

        resetn   = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset div_by_zero", int'(div_by_zero), 0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat, bc);
            check($sformatf("vec%0d quotient", i), int'(quotient), vecs[i].q);
            check($sformatf("vec%0d remainder", i), int'(remainder), vecs[i].r);
            check($sformatf("vec%0d div_by_zero", i), int'(div_by_zero), vecs[i].z);
            check($sformatf("vec%0d done latency", i), lat, (vecs[i].z != 0) ? 0 : W);
            check($sformatf("vec%0d busy cycles", i), bc, (vecs[i].z != 0) ? 0 : W);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d done width", i), int'(done), 0);
            check($sformatf("vec%0d quotient held", i), int'(quotient), vecs[i].q);
        end

        // Start and operand changes during CALC must not disturb the operation
        dividend = W'(10);
        divisor  = W'(3);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = W'(1);
        divisor  = W'(1);
        @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) ndone++;
            @(posedge clock);
            #1;
        end
        check("ignore-start done count", ndone, 1);
        check("ignore-start quotient", int'(quotient), 3);
        check("ignore-start remainder", int'(remainder), 1);

        // Asynchronous reset in the second CALC cycle
        dividend = W'(14);
        divisor  = W'(5);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("async reset quotient", int'(quotient), 0);
        check("async reset remainder", int'(remainder), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset div_by_zero", int'(div_by_zero), 0);
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        check("async reset no done", ndone, 0);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        do_op(14, 5, lat, bc);
        check("after reset quotient", int'(quotient), 2);
        check("after reset remainder", int'(remainder), 4);
        check("after reset latency", lat, W);
        @(posedge clock);
        #1;

        // Exhaustive sweep with start held high
        for (int a = 0; a <= ALL_ONE; a++) begin
            for (int b = 0; b <= ALL_ONE; b++) begin
                dividend = W'(a);
                divisor  = W'(b);
                start    = 1'b1;
                seen     = 1'b0;
                for (int k = 0; k < BOUND && !seen; k++) begin
                    @(posedge clock);
                    #1;
                    if (done) seen = 1'b1;
                end
                model(a, b, q, r, z);
                check($sformatf("sweep %0d/%0d done seen", a, b), int'(seen), 1);
                check($sformatf("sweep %0d/%0d quotient", a, b), int'(quotient), q);
                check($sformatf("sweep %0d/%0d remainder", a, b), int'(remainder), r);
                check($sformatf("sweep %0d/%0d div_by_zero", a, b), int'(div_by_zero), z);
                if (b != 0) begin
                    check($sformatf("sweep %0d/%0d invariant", a, b),
                          int'(quotient) * b + int'(remainder), a);
                end
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // Random single operations
        for (int n = 0; n < 40; n++) begin
            int a, b;
            a = int'($urandom_range(0, ALL_ONE));
            b = int'($urandom_range(0, ALL_ONE));
            do_op(a, b, lat, bc);
            model(a, b, q, r, z);
            check($sformatf("rand %0d/%0d quotient", a, b), int'(quotient), q);
            check($sformatf("rand %0d/%0d remainder", a, b), int'(remainder), r);
            check($sformatf("rand %0d/%0d div_by_zero", a, b), int'(div_by_zero), z);
            check($sformatf("rand %0d/%0d latency", a, b), lat, (z != 0) ? 0 : W);
            @(posedge clock);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
